multi_seg_scan_driver: RTL and testbench

- Parametrised N-digit time-multiplexed seven-segment scan driver; successor to the fixed 4-digit BCD driver.
- Adds a configurable digit count, per-digit decimal points, leading-zero blanking and PWM brightness.
- Frame-synchronous input snapshot prevents tearing; an anode dead cycle between slots suppresses ghosting.
- Sits between the board's BCD/counter datapath and the anode/cathode pins.

---
 rtl/sseg_pkg.sv | 31 +++
 rtl/multi_seg_scan_driver_if.sv | 28 ++
 rtl/bcd_to_sseg.sv | 27 ++
 rtl/multi_seg_scan_driver.sv | 136 +++++++++++++
 tb/tb_multi_seg_scan_driver.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - seven-segment pattern constants shared by the scan driver and its decoder
// Patterns are active-high, bit 0 = segment a ... bit 6 = segment g.
package sseg_pkg;

    localparam int SEG_W = 7;

    // Cathode bit positions within a pattern.
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/multi_seg_scan_driver_if.sv
// rtl/multi_seg_scan_driver_if.sv - display datapath/pin bundle for the scan driver
// master: the BCD/counter datapath side (drives digits, dp, blanking, brightness).
// slave : the scan driver (consumes digits, drives anode/cathode/dp pins).
interface multi_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIM_BITS   = 3
);
    import sseg_pkg::*;

    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz_i;
    logic [DIM_BITS-1:0]     bright_i;
    logic [NUM_DIGITS-1:0]   sseg_a_o;
    logic [SEG_W-1:0]        sseg_c_o;
    logic                    sseg_dp_o;

    modport master (
        output bcd_in, dp_in, blank_lz_i, bright_i,
        input  sseg_a_o, sseg_c_o, sseg_dp_o
    );

    modport slave (
        input  bcd_in, dp_in, blank_lz_i, bright_i,
        output sseg_a_o, sseg_c_o, sseg_dp_o
    );

endinterface

// File: rtl/bcd_to_sseg.sv
// rtl/bcd_to_sseg.sv - combinational 4-bit digit to active-high seven-segment decoder
// Ports: bcd_i (digit value), seg_o (pattern {g..a}); 10-15 decode to a dash.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0]       bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/multi_seg_scan_driver.sv
// rtl/multi_seg_scan_driver.sv - N-digit time-multiplexed seven-segment scan driver
// Ports: clk, rst (sync active-high); disp (slave): bcd_in/dp_in/blank_lz_i/bright_i in,
// sseg_a_o (one-hot-or-none anodes), sseg_c_o {g..a}, sseg_dp_o out, all registered.
module multi_seg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 100000,
    parameter int DIM_BITS         = 3,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input logic                    clk,
    input logic                    rst,
    multi_seg_scan_driver_if.slave disp
);

    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int SUB = CLK_DIV / (2 ** DIM_BITS);

    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [SEG_W-1:0]      CAT_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0]           p_q, p_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    snap_blz_q, snap_blz_d;
    logic                    started_q, started_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [SEG_W-1:0]        cat_q, cat_d;
    logic                    dp_q, dp_d;

    logic                    p_wrap;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              cur_digit;
    logic [SEG_W-1:0]        dec_seg;
    logic [SEG_W-1:0]        seg_hi;
    logic [31:0]             on_limit;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_hot;

    // Prescaler, digit index and frame-boundary snapshot.
    always_comb begin
        p_wrap     = (p_q == P_LAST);
        frame_end  = p_wrap && (idx_q == I_LAST);
        p_d        = p_wrap ? '0 : p_q + 1'b1;
        idx_d      = idx_q;
        if (p_wrap) begin
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        snap_blz_d = snap_blz_q;
        if (frame_end) begin
            snap_bcd_d = disp.bcd_in;
            snap_dp_d  = disp.dp_in;
            snap_blz_d = disp.blank_lz_i;
        end
    end

    // Leading-zero blanking: walk down from the top digit until the first nonzero one.
    always_comb begin : blank_logic
        logic seen_nz;
        seen_nz    = 1'b0;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (snap_blz_q && !seen_nz && (snap_bcd_q[4*k +: 4] == 4'd0)) begin
                blank_mask[k] = 1'b1;
            end
            if (snap_bcd_q[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
        end
    end

    assign cur_digit = snap_bcd_q[4*int'(idx_q) +: 4];

    bcd_to_sseg u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    // PWM window 1 <= p < (bright+1)*SUB; p=0 is the anti-ghosting dead cycle.
    always_comb begin
        on_limit  = (32'(disp.bright_i) + 32'd1) * 32'(SUB);
        lit       = (p_q != '0) && (32'(p_q) < on_limit);
        an_hot    = lit ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q) : '0;
        seg_hi    = blank_mask[idx_q] ? SEG_BLANK : dec_seg;
        an_d      = (ANODE_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
        cat_d     = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        dp_d      = (SEG_ACTIVE_LOW != 0) ? ~snap_dp_q[idx_q] : snap_dp_q[idx_q];
        started_d = 1'b1;
        // Pins stay in the reset state for the first edge after release.
        if (!started_q) begin
            an_d  = AN_OFF;
            cat_d = CAT_OFF;
            dp_d  = DP_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= '0;
            idx_q      <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            snap_blz_q <= 1'b0;
            started_q  <= 1'b0;
            an_q       <= AN_OFF;
            cat_q      <= CAT_OFF;
            dp_q       <= DP_OFF;
        end else begin
            p_q        <= p_d;
            idx_q      <= idx_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            snap_blz_q <= snap_blz_d;
            started_q  <= started_d;
            an_q       <= an_d;
            cat_q      <= cat_d;
            dp_q       <= dp_d;
        end
    end

    assign disp.sseg_a_o  = an_q;
    assign disp.sseg_c_o  = cat_q;
    assign disp.sseg_dp_o = dp_q;

endmodule

// File: tb/tb_multi_seg_scan_driver.sv
// tb/tb_multi_seg_scan_driver.sv - scoreboard testbench for multi_seg_scan_driver
module tb_multi_seg_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multi_seg_scan_driver_if #(.NUM_DIGITS(4), .DIM_BITS(3)) dif ();

    multi_seg_scan_driver #(
        .NUM_DIGITS       (4),
        .CLK_DIV          (8),
        .DIM_BITS         (3),
        .ANODE_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW   (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif)
    );

    typedef struct {
        logic [3:0] a;
        logic [6:0] c;
        logic       dp;
        bit         chk_c;
        int         slot;
        int         p;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Inputs that the DUT will latch at the next frame boundary / has latched.
    logic [15:0] sb_bcd;
    logic [3:0]  sb_dp;
    logic        sb_blz;

    function automatic logic [6:0] ref_pat(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected pins for one 32-cycle frame, using the snapshot the DUT already holds.
    task automatic push_frame(input bit first);
        int         thr;
        logic       seen;
        logic [3:0] blank;
        logic [3:0] d;
        logic [3:0] one;
        bit         on;
        exp_t       e;
        thr   = int'(dif.bright_i) + 1;
        seen  = 1'b0;
        blank = 4'b0000;
        one   = 4'b0001;
        for (int k = 3; k >= 1; k--) begin
            d = sb_bcd[4*k +: 4];
            if (sb_blz && !seen && d == 4'd0) blank[k] = 1'b1;
            if (d != 4'd0) seen = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 8; p++) begin
                on      = (p >= 1) && (p < thr);
                e.a     = on ? ~(one << k) : 4'hF;
                e.c     = blank[k] ? 7'h7F : ~ref_pat(sb_bcd[4*k +: 4]);
                e.dp    = ~sb_dp[k];
                e.chk_c = on;
                e.slot  = k;
                e.p     = p;
                if (first && k == 0 && p == 0) begin
                    e.c     = 7'h7F;
                    e.dp    = 1'b1;
                    e.chk_c = 1'b1;
                end
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: no expectation queued at t=%0t", $time);
            end else begin
                e = sb_q.pop_front();
                if (dif.sseg_a_o !== e.a) begin
                    n_fail++;
                    $display("FAIL anode slot=%0d p=%0d got=%h exp=%h", e.slot, e.p, dif.sseg_a_o, e.a);
                end
                if (e.chk_c) begin
                    n_tests++;
                    if (dif.sseg_c_o !== e.c) begin
                        n_fail++;
                        $display("FAIL cathode slot=%0d p=%0d got=%h exp=%h", e.slot, e.p, dif.sseg_c_o, e.c);
                    end
                    n_tests++;
                    if (dif.sseg_dp_o !== e.dp) begin
                        n_fail++;
                        $display("FAIL dp slot=%0d p=%0d got=%b exp=%b", e.slot, e.p, dif.sseg_dp_o, e.dp);
                    end
                end
            end
        end
    endtask

    // Drive new inputs at a frame start; they show up one frame later.
    task automatic frame(input logic [15:0] bcd, input logic [3:0] dp, input logic blz, input logic [2:0] br);
        dif.bcd_in     = bcd;
        dif.dp_in      = dp;
        dif.blank_lz_i = blz;
        dif.bright_i   = br;
        push_frame(1'b0);
        sb_bcd = bcd;
        sb_dp  = dp;
        sb_blz = blz;
        drain(32);
    endtask

    task automatic check_idle(input string tag);
        n_tests++;
        if (dif.sseg_a_o !== 4'hF) begin
            n_fail++;
            $display("FAIL %s_anode got=%h exp=f", tag, dif.sseg_a_o);
        end
        n_tests++;
        if (dif.sseg_c_o !== 7'h7F) begin
            n_fail++;
            $display("FAIL %s_cathode got=%h exp=7f", tag, dif.sseg_c_o);
        end
        n_tests++;
        if (dif.sseg_dp_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_dp got=%b exp=1", tag, dif.sseg_dp_o);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        dif.bcd_in     = 16'h0000;
        dif.dp_in      = 4'b0000;
        dif.blank_lz_i = 1'b0;
        dif.bright_i   = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst    = 1'b0;
        sb_bcd = 16'h0000;
        sb_dp  = 4'b0000;
        sb_blz = 1'b0;
        push_frame(1'b1);
        drain(32);
    endtask

    task automatic test_scan_order();
        frame(16'h1234, 4'b0000, 1'b0, 3'd7);
        frame(16'h1234, 4'b0000, 1'b0, 3'd7);
    endtask

    task automatic test_blanking();
        frame(16'h00A5, 4'b0000, 1'b1, 3'd7);
        frame(16'h0000, 4'b0000, 1'b1, 3'd7);
        frame(16'h0000, 4'b0000, 1'b1, 3'd7);
    endtask

    task automatic test_brightness_dp();
        frame(16'h1234, 4'b0100, 1'b0, 3'd0);
        frame(16'h1234, 4'b0100, 1'b0, 3'd3);
        frame(16'h1234, 4'b0100, 1'b0, 3'd3);
    endtask

    task automatic test_snapshot();
        dif.dp_in      = 4'b0000;
        dif.blank_lz_i = 1'b0;
        dif.bright_i   = 3'd7;
        push_frame(1'b0);
        sb_dp  = 4'b0000;
        sb_blz = 1'b0;
        drain(11);
        dif.bcd_in = 16'h5678;
        sb_bcd     = 16'h5678;
        drain(21);
        frame(16'h5678, 4'b0000, 1'b0, 3'd7);
    endtask

    task automatic test_reset_mid_frame();
        push_frame(1'b0);
        drain(19);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        check_idle("mid_reset");
        rst    = 1'b0;
        sb_bcd = 16'h0000;
        sb_dp  = 4'b0000;
        sb_blz = 1'b0;
        push_frame(1'b1);
        sb_bcd = dif.bcd_in;
        drain(32);
        frame(16'h5678, 4'b0000, 1'b0, 3'd7);
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_blanking();
        test_brightness_dp();
        test_snapshot();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
